// File: rtl/spi_sd_block_responder.sv
// SPI-mode SD-card responder: parses 6-byte commands, answers R1, and serves
// single-block reads (CMD17) and writes (CMD24) from an external sync memory.
// Optional build macro SD_RESP_DATA_CRC_EN: send a real CRC16-CCITT after read
// data instead of 0xFF 0xFF.
module spi_sd_block_responder #(
   parameter int unsigned BLK_WIDTH  = 4,
   parameter int unsigned BUSY_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cs,
   input  logic                   sclk,
   input  logic                   mosi,
   output logic                   miso,
   output logic [BLK_WIDTH+8:0]   mem_addr,
   input  logic [7:0]             mem_rdata,
   output logic [7:0]             mem_wdata,
   output logic                   mem_we,
   output logic [5:0]             last_cmd,
   output logic                   blk_wr_done
);
   localparam int unsigned AW = BLK_WIDTH + 9;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_CMD_RX   = 4'd1;
   localparam logic [3:0] S_RESP_GAP = 4'd2;
   localparam logic [3:0] S_RESP_R1  = 4'd3;
   localparam logic [3:0] S_RD_GAP   = 4'd4;
   localparam logic [3:0] S_RD_TOKEN = 4'd5;
   localparam logic [3:0] S_RD_DATA  = 4'd6;
   localparam logic [3:0] S_RD_CRC   = 4'd7;
   localparam logic [3:0] S_WR_TOKEN = 4'd8;
   localparam logic [3:0] S_WR_DATA  = 4'd9;
   localparam logic [3:0] S_WR_CRC   = 4'd10;
   localparam logic [3:0] S_WR_DRESP = 4'd11;
   localparam logic [3:0] S_WR_BUSY  = 4'd12;

   logic [1:0]    cs_sync_q;
   logic [2:0]    sclk_sync_q;
   logic [1:0]    mosi_sync_q;
   logic          cs_s, mosi_s, rise_c, fall_c, byte_done_c;
   logic [7:0]    rx_byte_c, tx_byte_c;

   logic [3:0]    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [6:0]    rx_sr_q, rx_sr_d;
   logic [6:0]    tx_sr_q, tx_sr_d;
   logic          miso_q, miso_d;
   logic [8:0]    off_q, off_d;
   logic [5:0]    cmd_q, cmd_d;
   logic [31:0]   arg_q, arg_d;
   logic [7:0]    r1_q, r1_d;
   logic          in_idle_q, in_idle_d;
   logic          cmd55_q, cmd55_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;
   logic          mem_we_q, mem_we_d;
   logic [5:0]    last_cmd_q, last_cmd_d;
   logic          blk_wr_done_q, blk_wr_done_d;
`ifdef SD_RESP_DATA_CRC_EN
   logic [15:0]   crc_q, crc_d;

   // CRC16-CCITT (poly 0x1021) advanced by one byte, MSB first
   function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction
`endif

   // Two-flop synchronisers for the asynchronous SPI pins (extra sclk tap for edges)
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync_q   <= 2'b11;
         sclk_sync_q <= 3'b000;
         mosi_sync_q <= 2'b11;
      end else begin
         cs_sync_q   <= {cs_sync_q[0], cs};
         sclk_sync_q <= {sclk_sync_q[1:0], sclk};
         mosi_sync_q <= {mosi_sync_q[0], mosi};
      end
   end

   assign cs_s        = cs_sync_q[1];
   assign mosi_s      = mosi_sync_q[1];
   assign rise_c      = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign fall_c      = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign byte_done_c = ~cs_s & rise_c & (bit_cnt_q == 3'd7);
   assign rx_byte_c   = {rx_sr_q, mosi_s};

   // Byte to put on miso for the byte slot owned by the current state
   always_comb begin
      tx_byte_c = 8'hFF;
      case (state_q)
         S_RESP_R1:  tx_byte_c = r1_q;
         S_RD_TOKEN: tx_byte_c = 8'hFE;
         S_RD_DATA:  tx_byte_c = mem_rdata;
`ifdef SD_RESP_DATA_CRC_EN
         S_RD_CRC:   tx_byte_c = (off_q == 9'd0) ? crc_q[15:8] : crc_q[7:0];
`endif
         S_WR_DRESP: tx_byte_c = 8'h05;
         S_WR_BUSY:  tx_byte_c = 8'h00;
         default:    tx_byte_c = 8'hFF;
      endcase
   end

   // Next-state: bit framing, miso shifting and per-byte protocol decisions
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      rx_sr_d       = rx_sr_q;
      tx_sr_d       = tx_sr_q;
      miso_d        = miso_q;
      off_d         = off_q;
      cmd_d         = cmd_q;
      arg_d         = arg_q;
      r1_d          = r1_q;
      in_idle_d     = in_idle_q;
      cmd55_d       = cmd55_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_we_d      = 1'b0;
      last_cmd_d    = last_cmd_q;
      blk_wr_done_d = 1'b0;
`ifdef SD_RESP_DATA_CRC_EN
      crc_d         = crc_q;
`endif
      if (cs_s) begin
         state_d   = S_IDLE;
         bit_cnt_d = 3'd0;
         tx_sr_d   = 7'h7F;
         miso_d    = 1'b1;
         off_d     = 9'd0;
      end else begin
         if (rise_c) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            rx_sr_d   = {rx_sr_q[5:0], mosi_s};
         end
         if (fall_c) begin
            if (bit_cnt_q == 3'd0) begin
               miso_d  = tx_byte_c[7];
               tx_sr_d = tx_byte_c[6:0];
`ifdef SD_RESP_DATA_CRC_EN
               if (state_q == S_RD_DATA) crc_d = crc16_byte(crc_q, mem_rdata);
`endif
            end else begin
               miso_d  = tx_sr_q[6];
               tx_sr_d = {tx_sr_q[5:0], 1'b1};
            end
         end
         if (byte_done_c) begin
            case (state_q)
               S_IDLE: if (rx_byte_c[7:6] == 2'b01) begin
                  state_d = S_CMD_RX;
                  cmd_d   = rx_byte_c[5:0];
                  off_d   = 9'd0;
               end
               S_CMD_RX: begin
                  if (off_q == 9'd4) begin
                     state_d = S_RESP_GAP;
                     off_d   = 9'd0;
                  end else begin
                     arg_d = {arg_q[23:0], rx_byte_c};
                     off_d = off_q + 9'd1;
                  end
               end
               S_RESP_GAP: begin
                  state_d    = S_RESP_R1;
                  last_cmd_d = cmd_q;
                  cmd55_d    = (cmd_q == 6'd55);
                  case (cmd_q)
                     6'd0:  begin in_idle_d = 1'b1; r1_d = 8'h01; end
                     6'd1:  begin in_idle_d = 1'b0; r1_d = 8'h00; end
                     6'd8, 6'd16, 6'd55: r1_d = {7'd0, in_idle_q};
                     6'd41: if (cmd55_q) begin
                        in_idle_d = 1'b0;
                        r1_d      = 8'h00;
                     end else begin
                        r1_d = 8'h04 | {7'd0, in_idle_q};
                     end
                     6'd17, 6'd24: begin
                        if (in_idle_q)                    r1_d = 8'h05;
                        else if (arg_q[31:BLK_WIDTH] != '0) r1_d = 8'h40;
                        else                              r1_d = 8'h00;
                     end
                     default: r1_d = 8'h04 | {7'd0, in_idle_q};
                  endcase
               end
               S_RESP_R1: begin
                  off_d = 9'd0;
                  if (r1_q == 8'h00 && cmd_q == 6'd17) begin
                     state_d    = S_RD_GAP;
                     mem_addr_d = {arg_q[BLK_WIDTH-1:0], 9'd0};
`ifdef SD_RESP_DATA_CRC_EN
                     crc_d      = 16'h0000;
`endif
                  end else if (r1_q == 8'h00 && cmd_q == 6'd24) begin
                     state_d = S_WR_TOKEN;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
               S_RD_GAP:   state_d = S_RD_TOKEN;
               S_RD_TOKEN: state_d = S_RD_DATA;
               S_RD_DATA: begin
                  if (off_q == 9'd511) begin
                     state_d = S_RD_CRC;
                     off_d   = 9'd0;
                  end else begin
                     off_d      = off_q + 9'd1;
                     mem_addr_d = {arg_q[BLK_WIDTH-1:0], off_q + 9'd1};
                  end
               end
               S_RD_CRC: begin
                  if (off_q == 9'd1) begin
                     state_d = S_IDLE;
                     off_d   = 9'd0;
                  end else begin
                     off_d = off_q + 9'd1;
                  end
               end
               S_WR_TOKEN: begin
                  if (rx_byte_c == 8'hFE) begin
                     state_d = S_WR_DATA;
                     off_d   = 9'd0;
                  end else if (rx_byte_c != 8'hFF) begin
                     state_d = S_IDLE;
                  end
               end
               S_WR_DATA: begin
                  mem_we_d    = 1'b1;
                  mem_wdata_d = rx_byte_c;
                  mem_addr_d  = {arg_q[BLK_WIDTH-1:0], off_q};
                  if (off_q == 9'd511) begin
                     state_d = S_WR_CRC;
                     off_d   = 9'd0;
                  end else begin
                     off_d = off_q + 9'd1;
                  end
               end
               S_WR_CRC: begin
                  if (off_q == 9'd1) begin
                     state_d = S_WR_DRESP;
                     off_d   = 9'd0;
                  end else begin
                     off_d = off_q + 9'd1;
                  end
               end
               S_WR_DRESP: begin
                  blk_wr_done_d = 1'b1;
                  state_d       = S_WR_BUSY;
                  off_d         = 9'd0;
               end
               S_WR_BUSY: begin
                  if (off_q == 9'(BUSY_BYTES - 1)) begin
                     state_d = S_IDLE;
                     off_d   = 9'd0;
                  end else begin
                     off_d = off_q + 9'd1;
                  end
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         bit_cnt_q     <= 3'd0;
         rx_sr_q       <= 7'd0;
         tx_sr_q       <= 7'h7F;
         miso_q        <= 1'b1;
         off_q         <= 9'd0;
         cmd_q         <= 6'd0;
         arg_q         <= 32'd0;
         r1_q          <= 8'hFF;
         in_idle_q     <= 1'b1;
         cmd55_q       <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= 8'd0;
         mem_we_q      <= 1'b0;
         last_cmd_q    <= 6'd0;
         blk_wr_done_q <= 1'b0;
`ifdef SD_RESP_DATA_CRC_EN
         crc_q         <= 16'h0000;
`endif
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_sr_q       <= rx_sr_d;
         tx_sr_q       <= tx_sr_d;
         miso_q        <= miso_d;
         off_q         <= off_d;
         cmd_q         <= cmd_d;
         arg_q         <= arg_d;
         r1_q          <= r1_d;
         in_idle_q     <= in_idle_d;
         cmd55_q       <= cmd55_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_we_q      <= mem_we_d;
         last_cmd_q    <= last_cmd_d;
         blk_wr_done_q <= blk_wr_done_d;
`ifdef SD_RESP_DATA_CRC_EN
         crc_q         <= crc_d;
`endif
      end
   end

   assign miso        = miso_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_we      = mem_we_q;
   assign last_cmd    = last_cmd_q;
   assign blk_wr_done = blk_wr_done_q;

endmodule

// File: tb/tb_spi_sd_block_responder.sv
// Bench for spi_sd_block_responder: SPI master driver, sync memory, card model.
module tb_spi_sd_block_responder;
   localparam int unsigned BW    = 4;
   localparam int unsigned BUSY  = 4;
   localparam int unsigned AW    = BW + 9;
   localparam int unsigned MEMSZ = 1 << AW;
   localparam int unsigned HALF  = 40;

   logic          clk = 1'b0;
   logic          rst, cs, sclk, mosi, miso;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_rdata, mem_wdata;
   logic          mem_we, blk_wr_done;
   logic [5:0]    last_cmd;

   logic [7:0]    mem     [MEMSZ];
   logic [7:0]    ref_mem [MEMSZ];
   logic [7:0]    rd_buf  [512];
   int            fill_seed;
   int            checks = 0, errors = 0;
   int            done_cnt, we_cnt;
   logic          m_idle, m_p55;

   always #5 clk = ~clk;

   spi_sd_block_responder #(.BLK_WIDTH(BW), .BUSY_BYTES(BUSY)) dut (
      .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .last_cmd(last_cmd), .blk_wr_done(blk_wr_done)
   );

   function automatic logic [7:0] init_val(int i);
      return ((i >> 9) == 3) ? 8'(i) : 8'(i * 13 + fill_seed);
   endfunction

   // External synchronous memory, filled during reset
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEMSZ; i++) mem[i] <= init_val(i);
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr];
   end

   // Event counters for write strobes and block-done pulses
   always @(posedge clk) begin
      if (rst) begin
         done_cnt <= 0;
         we_cnt   <= 0;
      end else begin
         if (blk_wr_done) done_cnt <= done_cnt + 1;
         if (mem_we)      we_cnt   <= we_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit-serial CRC16-CCITT, init 0, over a whole block
   function automatic logic [15:0] crc_ref(input logic [7:0] d [512]);
      logic [15:0] c;
      logic        fb;
      c = 16'h0000;
      for (int n = 0; n < 512; n++) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[15] ^ d[n][b];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
         end
      end
      return c;
   endfunction

   function automatic int mem_mismatches();
      int m;
      m = 0;
      for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) m++;
      return m;
   endfunction

   // Card-level R1 rules, tracking idle state and the CMD55 prefix
   task automatic model_r1(input logic [5:0] idx, input logic [31:0] arg, output logic [7:0] r1);
      case (idx)
         6'd0: begin m_idle = 1'b1; r1 = 8'h01; end
         6'd1: begin m_idle = 1'b0; r1 = 8'h00; end
         6'd8, 6'd16, 6'd55: r1 = {7'd0, m_idle};
         6'd41: begin
            if (m_p55) begin m_idle = 1'b0; r1 = 8'h00; end
            else r1 = 8'h04 | {7'd0, m_idle};
         end
         6'd17, 6'd24: begin
            if (m_idle) r1 = 8'h05;
            else if (64'(arg) >= 64'(2 ** BW)) r1 = 8'h40;
            else r1 = 8'h00;
         end
         default: r1 = 8'h04 | {7'd0, m_idle};
      endcase
      m_p55 = (idx == 6'd55);
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         #HALF;
         rx[i] = miso;
         sclk = 1'b1;
         #HALF;
         sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      cs = 1'b0;
      #100;
   endtask

   task automatic cs_high();
      #HALF;
      cs = 1'b1;
      #200;
   endtask

   // Full command frame, gap byte check, and R1 capture (cs left low)
   task automatic sd_cmd(input logic [5:0] idx, input logic [31:0] arg, output logic [7:0] r1);
      logic [7:0] b;
      spi_byte(8'h40 | {2'b00, idx}, b);
      spi_byte(arg[31:24], b);
      spi_byte(arg[23:16], b);
      spi_byte(arg[15:8], b);
      spi_byte(arg[7:0], b);
      spi_byte((idx == 6'd0) ? 8'h95 : 8'h01, b);
      spi_byte(8'hFF, b);
      chk("gap_ff", 32'(b), 32'hFF);
      spi_byte(8'hFF, r1);
   endtask

   task automatic cmd_check(input logic [5:0] idx, input logic [31:0] arg);
      logic [7:0] r1, exp;
      model_r1(idx, arg, exp);
      sd_cmd(idx, arg, r1);
      chk("r1", 32'(r1), 32'(exp));
      chk("last_cmd", 32'(last_cmd), 32'(idx));
   endtask

   initial begin
      logic [7:0]  b, exp;
      logic [15:0] crcv;
      int          d0, w0, mm;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [5:0]  cmd_list [9];

      cs = 1'b1; sclk = 1'b0; mosi = 1'b1; rst = 1'b1;
      m_idle = 1'b1; m_p55 = 1'b0;
      fill_seed = int'($urandom);
      for (int i = 0; i < MEMSZ; i++) ref_mem[i] = init_val(i);
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #20;

      chk("rst_miso", 32'(miso), 32'd1);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_last_cmd", 32'(last_cmd), 32'd0);
      chk("rst_blk_wr_done", 32'(blk_wr_done), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);

      // CMD0 then CMD17 while still idle: 0x05 with no data phase
      cs_low(); cmd_check(6'd0, 32'd0); cs_high();
      cs_low(); cmd_check(6'd17, 32'd0);
      spi_byte(8'hFF, b); chk("pre_init_no_tok0", 32'(b), 32'hFF);
      spi_byte(8'hFF, b); chk("pre_init_no_tok1", 32'(b), 32'hFF);
      cs_high();

      // Init sequence and illegal CMD41
      cs_low(); cmd_check(6'd8, 32'h1AA); cs_high();
      cs_low(); cmd_check(6'd55, 32'd0); cs_high();
      cs_low(); cmd_check(6'd41, 32'd0); cs_high();
      cs_low(); cmd_check(6'd41, 32'd0); cs_high();

      // Block read of block 3
      cs_low(); cmd_check(6'd17, 32'd3);
      spi_byte(8'hFF, b); chk("rd_gap", 32'(b), 32'hFF);
      spi_byte(8'hFF, b); chk("rd_token", 32'(b), 32'hFE);
      for (int n = 0; n < 512; n++) begin
         spi_byte(8'hFF, b);
         rd_buf[n] = b;
         chk("rd_data", 32'(b), 32'(ref_mem[3*512 + n]));
      end
      crcv = crc_ref(rd_buf);
`ifndef SD_RESP_DATA_CRC_EN
      crcv = 16'hFFFF;
`endif
      spi_byte(8'hFF, b); chk("rd_crc_hi", 32'(b), 32'(crcv[15:8]));
      spi_byte(8'hFF, b); chk("rd_crc_lo", 32'(b), 32'(crcv[7:0]));
      spi_byte(8'hFF, b); chk("rd_after", 32'(b), 32'hFF);
      cs_high();

      // Block write of 0xA5 to block 2
      d0 = done_cnt; w0 = we_cnt;
      cs_low(); cmd_check(6'd24, 32'd2);
      spi_byte(8'hFF, b); chk("wr_pre0", 32'(b), 32'hFF);
      spi_byte(8'hFF, b); chk("wr_pre1", 32'(b), 32'hFF);
      spi_byte(8'hFE, b);
      for (int n = 0; n < 512; n++) begin
         spi_byte(8'hA5, b);
         ref_mem[2*512 + n] = 8'hA5;
      end
      spi_byte(8'h12, b);
      spi_byte(8'h34, b);
      chk("wr_done_early", 32'(done_cnt), 32'(d0));
      spi_byte(8'hFF, b); chk("wr_dresp", 32'(b), 32'h05);
      chk("wr_done_pulse", 32'(done_cnt), 32'(d0 + 1));
      for (int k = 0; k < BUSY; k++) begin
         spi_byte(8'hFF, b); chk("wr_busy", 32'(b), 32'h00);
      end
      spi_byte(8'hFF, b); chk("wr_after_busy", 32'(b), 32'hFF);
      cs_high();
      chk("wr_strobes", 32'(we_cnt), 32'(w0 + 512));
      chk("wr_done_once", 32'(done_cnt), 32'(d0 + 1));
      mm = mem_mismatches();
      chk("wr_mem", 32'(mm), 32'd0);

      // Out-of-range block
      cs_low(); cmd_check(6'd17, 32'(2 ** BW));
      spi_byte(8'hFF, b); chk("range_no_tok0", 32'(b), 32'hFF);
      spi_byte(8'hFF, b); chk("range_no_tok1", 32'(b), 32'hFF);
      cs_high();

      // Abort a write after 100 random data bytes
      d0 = done_cnt; w0 = we_cnt;
      cs_low(); cmd_check(6'd24, 32'd5);
      spi_byte(8'hFE, b);
      for (int n = 0; n < 100; n++) begin
         exp = 8'($urandom);
         spi_byte(exp, b);
         ref_mem[5*512 + n] = exp;
      end
      cs_high();
      chk("abort_miso", 32'(miso), 32'd1);
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
      chk("abort_strobes", 32'(we_cnt), 32'(w0 + 100));
      mm = mem_mismatches();
      chk("abort_mem", 32'(mm), 32'd0);
      cs_low(); cmd_check(6'd0, 32'd0); cs_high();

      // Random commands against the card model
      cmd_list = '{6'd0, 6'd1, 6'd8, 6'd16, 6'd17, 6'd24, 6'd41, 6'd55, 6'd0};
      for (int k = 0; k < 4; k++) begin
         cmd_list[8] = 6'($urandom);
         idx = cmd_list[$urandom_range(0, 8)];
         arg = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 2 ** BW - 1)) : 32'($urandom);
         cs_low(); cmd_check(idx, arg); cs_high();
      end
      chk("final_done", 32'(done_cnt), 32'(d0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_sd_block_responder.md
Name: spi_sd_block_responder

Overview:
- SPI-mode SD-card responder (slave) for closed-loop bench and on-board loopback of the autotest SD master.
- Parses 6-byte SPI-mode SD commands and answers with R1.
- Serves single-block reads (CMD17) and single-block writes (CMD24) from a 512-byte-per-block external synchronous memory.
- Lets the vector-fetch and result-store paths run without a physical card.

Parameters:
- BLK_WIDTH, 4: block-number bits; memory holds 2**BLK_WIDTH blocks of 512 bytes.
- BUSY_BYTES, 4: number of 0x00 busy bytes sent after a write data-response.

Ports:
- clk  in  1  system clock; every register is clocked here.
- rst  in  1  synchronous reset, active-high.
- cs  in  1  SPI chip select, active low, asynchronous to clk.
- sclk  in  1  SPI clock, mode 0; frequency ≤ clk/8.
- mosi  in  1  master-to-responder data.
- miso  out  1  responder-to-master data; reset 1.
- mem_addr  out  BLK_WIDTH+9  byte address = block*512 + offset; reset 0.
- mem_rdata  in  8  read data, valid 1 clk after mem_addr.
- mem_wdata  out  8  write data; reset 0.
- mem_we  out  1  one-clk write strobe; reset 0.
- last_cmd  out  6  index of last accepted command; reset 0.
- blk_wr_done  out  1  one-clk pulse when a write block is committed; reset 0.

Behaviour:
- Input sync and sampling:
  - cs, sclk and mosi pass through 2-FF synchronisers.
  - sclk rising edge (detected on synced value) samples mosi, MSB first.
  - sclk falling edge shifts the next miso bit.
  - The first bit of each response byte is on miso before the first rising edge of that byte.
- Byte framing: bit counter 0..7, cleared while cs high.
- cs deasserted in any state: return to IDLE, miso=1, bit counter cleared, partial command discarded, in_idle flag kept.
- Flags and idle output:
  - in_idle flag: set by reset and CMD0; cleared by CMD1, or by CMD41 when the preceding command was CMD55.
  - miso=1 in every state that is not transmitting.
- FSM states and transitions:
  - IDLE: wait for a received byte with bits[7:6]=01 → CMD_RX (byte 0 stored). Any other byte is ignored.
  - CMD_RX: collect 5 more bytes (arg[31:0], crc); CRC ignored → RESP_GAP.
  - RESP_GAP: send one 0xFF byte → RESP_R1.
  - RESP_R1: send R1, then:
    - CMD17 ok → RD_GAP.
    - CMD24 ok → WR_TOKEN.
    - otherwise → IDLE.
  - R1 values:
    - bit0 = in_idle.
    - Supported commands (0, 1, 8, 16, 17, 24, 41, 55): R1=0x00|in_idle.
    - CMD41 without a preceding CMD55 is illegal.
    - Illegal command: R1=0x04|in_idle.
    - CMD17/CMD24 while in_idle=1: 0x05, no data phase.
    - CMD17/CMD24 with arg ≥ 2**BLK_WIDTH (block addressing): 0x40, no data phase.
  - RD_GAP: one 0xFF → RD_TOKEN: 0xFE → RD_DATA: 512 bytes from mem[arg*512+0..511] → RD_CRC: 2 bytes → IDLE.
    - mem_addr is issued at least 2 clk before the byte's first falling edge.
  - WR_TOKEN: ignore 0xFF bytes; 0xFE → WR_DATA. Any other byte → IDLE with no write.
  - WR_DATA: each received byte asserts mem_we for 1 clk at mem_addr = arg*512+n, n = 0..511.
  - WR_CRC: 2 bytes ignored → WR_DRESP: send 0x05; blk_wr_done pulses at the end of this byte → WR_BUSY: BUSY_BYTES × 0x00 → IDLE.
- last_cmd updates on entry to RESP_R1, including for illegal commands.
- CS abort mid-write: bytes already written stay written; blk_wr_done is not pulsed.
- Offset counter is 9 bits and must not wrap into the next block.

Optional Feature:
- SD_RESP_DATA_CRC_EN
  - Defined: RD_CRC sends the CRC16-CCITT (poly 0x1021, init 0x0000) of the 512 read bytes, MSB first.
  - Not defined: RD_CRC sends 0xFF 0xFF.
  - Write CRC is ignored in both builds.

Test Plan:
- Reset, then CMD0 (40 00 00 00 00 95) → 0xFF gap byte, R1=0x01; last_cmd=0.
- CMD55, then CMD41 arg 0 → R1 0x01 then 0x00. A subsequent CMD41 without CMD55 → 0x04.
- After init, preload block 3 with pattern (addr&0xFF), CMD17 arg 3 → R1 0x00, FF, FE, bytes 00..FF twice, then CRC:
  - FF FF when the macro is undefined.
  - The computed CRC16 when SD_RESP_DATA_CRC_EN is defined.
- CMD24 arg 2, then FF FF FE + 512 bytes of 0xA5 + 2 CRC → R1 0x00, data response 0x05, BUSY_BYTES×00, blk_wr_done pulse; mem[1024..1535]=0xA5.
- CMD17 arg 2**BLK_WIDTH → R1 0x40, no FE token. CMD17 before init → 0x05.
- cs raised after 100 bytes of a CMD24 data phase → miso=1, FSM in IDLE, no blk_wr_done; next CMD0 answered normally with 0x01.
